// File: rtl/dram_rout_collector.sv
// Deserialises the serial ROUT lanes of the DRAM CIM array into one AES state.
// After a start strobe it waits RD_LAT cycles, shifts BITS bits per lane, then holds the state for a valid/ready handshake.
module dram_rout_collector #(
    parameter int unsigned LANES     = 16,
    parameter int unsigned BITS      = 8,
    parameter int unsigned RD_LAT    = 2,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    start,
    input  logic [LANES-1:0]        rout,
    output logic [LANES*BITS-1:0]   state_out,
    output logic                    state_vld,
    input  logic                    state_rdy,
    output logic                    busy,
    output logic                    ovr
);

    localparam int unsigned LAT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
    localparam int unsigned BIT_W = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SHIFT,
        HOLD
    } state_t;

    state_t            state, state_nx;
    logic [LAT_W-1:0]  lat_cnt, lat_nx;
    logic [BIT_W-1:0]  bit_cnt, bit_nx;
    logic [LANES-1:0]  rout_q;
    logic              shift_en;
    logic              ovr_nx;

    always_comb begin
        state_nx = state;
        lat_nx   = lat_cnt;
        bit_nx   = bit_cnt;
        shift_en = 1'b0;
        ovr_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = WAIT;
                    lat_nx   = '0;
                end
            end
            WAIT: begin
                ovr_nx = start;
                // RD_LAT+1 edges here so that rout_q holds bit 0 on the first SHIFT edge
                if (lat_cnt == LAT_LAST) begin
                    state_nx = SHIFT;
                    bit_nx   = '0;
                end else begin
                    lat_nx = lat_cnt + 1'b1;
                end
            end
            SHIFT: begin
                ovr_nx   = start;
                shift_en = 1'b1;
                if (bit_cnt == BIT_LAST) begin
                    state_nx = HOLD;
                end else begin
                    bit_nx = bit_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (state_rdy) begin
                    if (start) begin
                        state_nx = WAIT;
                        lat_nx   = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    ovr_nx = start;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            bit_cnt   <= '0;
            rout_q    <= '0;
            ovr       <= 1'b0;
            state_out <= '0;
        end else begin
            state   <= state_nx;
            lat_cnt <= lat_nx;
            bit_cnt <= bit_nx;
            rout_q  <= rout;
            ovr     <= ovr_nx;
            if (shift_en) begin
                // lane i owns byte i, which sits at the top end of the packed state
                for (int unsigned i = 0; i < LANES; i++) begin
                    if (MSB_FIRST) begin
                        state_out[(LANES-1-i)*BITS +: BITS] <=
                            {state_out[(LANES-1-i)*BITS +: BITS-1], rout_q[i]};
                    end else begin
                        state_out[(LANES-1-i)*BITS +: BITS] <=
                            {rout_q[i], state_out[(LANES-1-i)*BITS+1 +: BITS-1]};
                    end
                end
            end
        end
    end

    assign busy      = (state != IDLE);
    assign state_vld = (state == HOLD);

endmodule

// File: doc/dram_rout_collector.md
Name: dram_rout_collector

Overview:
Deserialises the 16 serial ROUT read-out lanes of the DRAM CIM array into one 128-bit AES state after an in-array AddRoundKey/SubBytes pass. Sits directly downstream of the DRAM array pins and upstream of the FPGA ShiftRows/MixColumns logic. The round controller pulses a start strobe when it launches an array read. The block waits a fixed read latency, shifts in BITS bits per lane, then presents the state with a valid/ready handshake.

Parameters:
LANES, 16, number of ROUT lanes; lane i produces state byte i.
BITS, 8, serial bits per lane per read.
RD_LAT, 2, cycles from start acceptance to the first valid bit; legal range 0..15.
MSB_FIRST, 1, 1 = the first bit on a lane is byte bit 7; 0 = the first bit is bit 0.

Ports:
CLK  in  1  system clock, all logic on the rising edge.
RST  in  1  asynchronous, active-high reset.
start  in  1  one-cycle strobe from the round controller: an array read has been launched.
rout  in  LANES  ROUT_1v8_1..16 packed; rout[i] = ROUT_1v8_(i+1).
state_out  out  LANES*BITS  collected state; byte i at bits [127-8i : 120-8i], so byte 0 is the MSB byte.
state_vld  out  1  state_out holds a complete state.
state_rdy  in  1  downstream accepts the state.
busy  out  1  high in every state except IDLE.
ovr  out  1  one-cycle pulse: a start was received while it could not be accepted.

Behaviour:
- Reset: the following are cleared asynchronously:
  - FSM goes to IDLE.
  - state_out=0, state_vld=0, busy=0, ovr=0.
  - All counters and the input register are cleared.
- Input register: rout is captured into rout_q on every edge. The shifter uses only rout_q.
- Timing reference: edge 0 is the rising edge at which start=1 is accepted.
  - Bit j (j=0..BITS-1) of every lane is the rout value present at edge RD_LAT+1+j.
  - state_vld goes high after edge RD_LAT+BITS+1, i.e. after edge 11 with the defaults.
- FSM states:
  - IDLE: start=1 -> WAIT, latency counter cleared.
  - WAIT: counts RD_LAT+1 edges, then -> SHIFT with the bit counter at 0.
  - SHIFT: each edge shifts one bit per lane from rout_q into that lane's byte register.
    - MSB_FIRST=1: shift left, new bit enters the LSB.
    - MSB_FIRST=0: shift right, new bit enters the MSB.
    - After BITS shifts -> HOLD and state_vld=1 on the same edge.
  - HOLD: state_out and state_vld are stable while state_rdy=0.
    - state_vld & state_rdy -> IDLE and state_vld=0 on the next edge.
    - If start=1 in the same cycle as the handshake, go to WAIT instead. The start is accepted and ovr is not pulsed.
- state_out is updated only in SHIFT and retains its last value in IDLE and HOLD.
- Start while busy:
  - In WAIT or SHIFT, or in HOLD without a handshake that cycle: the start is ignored, ovr=1 for exactly one cycle, and the current collection is unaffected.
  - Consecutive ignored starts give consecutive ovr pulses.
- rout is don't-care outside the sampling edges.
- Reset asserted mid-WAIT, SHIFT or HOLD: immediate return to IDLE, and all outputs take their reset values. No partial state is ever flagged valid.
- Counter widths are $clog2-sized. The bit counter wraps only via the SHIFT->HOLD transition.

Test Plan:
1. Reset: hold RST high with rout=16'hFFFF and start pulsing -> state_out=0, state_vld=0, busy=0, ovr=0 throughout.
2. Basic capture (defaults, state_rdy=1):
   - Stimulus: start at edge 0; lane i drives byte 0x11*i MSB-first on edges 3..10.
   - Required: state_vld high after edge 11 for exactly one cycle; state_out=128'h00112233445566778899aabbccddeeff; busy high after edges 0..11.
3. Backpressure:
   - Stimulus: as scenario 2 but state_rdy=0 for 20 cycles; start pulsed during HOLD; rout toggled randomly.
   - Required: state_out and state_vld remain stable; ovr pulses exactly one cycle; no new collection starts; handshake completes when state_rdy=1.
4. Back-to-back:
   - Stimulus: start asserted in the same cycle as the HOLD handshake; second pattern all lanes 0xA5.
   - Required: no ovr; second state_vld exactly RD_LAT+BITS+1 edges after that handshake edge; state_out=all bytes A5.
5. Reset mid-SHIFT:
   - Stimulus: RST pulsed after edge 6; then a fresh start with pattern lane i=i.
   - Required: outputs cleared immediately; second collection gives state_out=128'h000102030405060708090a0b0c0d0e0f with no corruption from the aborted read.
6. MSB_FIRST=0, RD_LAT=0:
   - Stimulus: lane 0 drives bit sequence 1,0,0,0,0,0,0,0 on edges 1..8.
   - Required: byte 0 = 8'h01; state_vld high after edge 9.
